// File: rtl/mux2_arbiter.sv
// ============================================================================
// mux2_arbiter : round-robin burst arbiter owning a shared 2:1 output mux.
// Optional macro MUX_ARB_FIXED_PRI_EN selects fixed A-wins-ties priority.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux2_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              b_ready,
  output logic              y_valid,
  output logic [DATA_W-1:0] y_data,
  output logic              y_last,
  input  logic              y_ready,
  output logic              sel,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

  localparam logic [3:0] C_LAST_CNT = 4'(MAX_BURST - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  state_t     w_winner;
  logic       r_sel;
  logic       w_sel_nxt;
  logic       r_rr_pri;
  logic       w_rr_pri_nxt;
  logic [3:0] r_beat_cnt;
  logic [3:0] w_beat_cnt_nxt;

  logic w_own_a;
  logic w_own_b;
  logic w_xfer;
  logic w_release;

  // Tie goes to B when pri=1, otherwise to A; a lone requester always wins.
  function automatic state_t arbitrate(input logic av, input logic bv, input logic pri);
    if (av && bv) return pri ? ST_OWN_B : ST_OWN_A;
    else if (av)  return ST_OWN_A;
    else if (bv)  return ST_OWN_B;
    else          return ST_IDLE;
  endfunction

  assign w_own_a = (r_state == ST_OWN_A);
  assign w_own_b = (r_state == ST_OWN_B);

  assign y_valid = (w_own_a & a_valid) | (w_own_b & b_valid);
  assign y_data  = r_sel ? b_data : a_data;
  assign y_last  = (w_own_a & a_last) | (w_own_b & b_last);
  assign a_ready = w_own_a & y_ready;
  assign b_ready = w_own_b & y_ready;
  assign sel     = r_sel;
  assign busy    = (r_state != ST_IDLE);

  assign w_xfer    = y_valid & y_ready;
  // A last flag coinciding with the beat limit is still a single release.
  assign w_release = w_xfer & (y_last | (r_beat_cnt == C_LAST_CNT));

`ifdef MUX_ARB_FIXED_PRI_EN
  assign w_rr_pri_nxt = 1'b0;
`else
  // After a release, priority points at the requester that did not own.
  assign w_rr_pri_nxt = w_release ? w_own_a : r_rr_pri;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    w_beat_cnt_nxt = r_beat_cnt;
    w_winner       = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        w_winner = arbitrate(a_valid, b_valid, r_rr_pri);
        if (w_winner != ST_IDLE) begin
          w_state_nxt    = w_winner;
          w_sel_nxt      = (w_winner == ST_OWN_B);
          w_beat_cnt_nxt = 4'd0;
        end
      end
      ST_OWN_A, ST_OWN_B: begin
        if (w_release) begin
          // Re-arbitrate in the release cycle so bursts chain with no gap.
          w_winner       = arbitrate(a_valid, b_valid, w_rr_pri_nxt);
          w_state_nxt    = w_winner;
          w_beat_cnt_nxt = 4'd0;
          if (w_winner != ST_IDLE) begin
            w_sel_nxt = (w_winner == ST_OWN_B);
          end
        end else if (w_xfer) begin
          w_beat_cnt_nxt = r_beat_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_beat_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sel      <= 1'b0;
      r_rr_pri   <= 1'b0;
      r_beat_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_rr_pri   <= w_rr_pri_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux2_arbiter.sv
// ============================================================================
// tb_mux2_arbiter : directed self-checking bench for mux2_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mux2_arbiter;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, a_last, a_ready;
  logic              b_valid, b_last, b_ready;
  logic [DATA_W-1:0] a_data, b_data, y_data;
  logic              y_valid, y_last, y_ready;
  logic              sel, busy;

  int n_checks = 0;
  int n_errors = 0;

  mux2_arbiter #(.DATA_W(DATA_W), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .y_valid(y_valid), .y_data(y_data), .y_last(y_last), .y_ready(y_ready),
    .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic exp_b;
    rst = 1'b1;
    a_valid = 1'b0; a_last = 1'b0; a_data = 8'h5A;
    b_valid = 1'b0; b_last = 1'b0; b_data = 8'hA5;
    y_ready = 1'b0;
    #3;
    check_val("rst_busy",    busy,    0);
    check_val("rst_sel",     sel,     0);
    check_val("rst_yvalid",  y_valid, 0);
    check_val("rst_aready",  a_ready, 0);
    check_val("rst_bready",  b_ready, 0);
    check_val("rst_ylast",   y_last,  0);
    check_val("rst_ydata",   y_data,  8'h5A);
    tick();
    rst = 1'b0;

    // A alone: grant one cycle after request, three beats with last.
    a_valid = 1'b1; a_data = 8'h11; y_ready = 1'b1;
    settle();
    check_val("a_idle_yvalid", y_valid, 0);
    check_val("a_idle_busy",   busy,    0);
    tick(); settle();
    check_val("a_b1_ydata",  y_data,  8'h11);
    check_val("a_b1_yvalid", y_valid, 1);
    check_val("a_b1_aready", a_ready, 1);
    check_val("a_b1_busy",   busy,    1);
    check_val("a_b1_sel",    sel,     0);
    tick(); a_data = 8'h22; settle();
    check_val("a_b2_ydata", y_data, 8'h22);
    tick(); a_data = 8'h33; a_last = 1'b1; settle();
    check_val("a_b3_ydata", y_data, 8'h33);
    check_val("a_b3_ylast", y_last, 1);
    // a_valid was still high in the release cycle, so A is re-granted.
    tick(); a_valid = 1'b0; a_last = 1'b0; settle();
    check_val("a_regrant_busy",   busy,    1);
    check_val("a_regrant_yvalid", y_valid, 0);

    // Owner idles while B waits: grant is held, no pre-emption.
    b_valid = 1'b1; b_data = 8'hB1;
    for (int k = 0; k < 2; k++) begin
      tick(); settle();
      check_val("hold_sel",    sel,     0);
      check_val("hold_bready", b_ready, 0);
      check_val("hold_busy",   busy,    1);
    end
    tick(); a_valid = 1'b1; a_data = 8'h44; a_last = 1'b1; settle();
    check_val("hold_end_ydata", y_data, 8'h44);
    check_val("hold_end_bready", b_ready, 0);
    tick(); a_valid = 1'b0; a_last = 1'b0; settle();
`ifdef MUX_ARB_FIXED_PRI_EN
    check_val("handoff_sel_fixed", sel, 0);
`else
    check_val("handoff_sel",    sel,     1);
    check_val("handoff_ydata",  y_data,  8'hB1);
    check_val("handoff_bready", b_ready, 1);
    check_val("handoff_aready", a_ready, 0);
`endif
    do_reset();

    // B alone, then asynchronous reset mid-burst at beat_cnt=2.
    b_valid = 1'b1; b_data = 8'hC1; y_ready = 1'b1;
    settle();
    check_val("b_idle_busy", busy, 0);
    tick(); settle();
    check_val("b_sel",    sel,     1);
    check_val("b_ydata",  y_data,  8'hC1);
    check_val("b_yvalid", y_valid, 1);
    tick(); b_data = 8'hC2;
    tick(); b_data = 8'hC3; settle();
    check_val("b_b3_ydata", y_data, 8'hC3);
    rst = 1'b1;
    #1;
    check_val("arst_yvalid", y_valid, 0);
    check_val("arst_bready", b_ready, 0);
    check_val("arst_sel",    sel,     0);
    check_val("arst_busy",   busy,    0);
    tick(); rst = 1'b0; b_valid = 1'b0;

    // Both valid continuously: MAX_BURST=4 bursts alternate with no gap.
    a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1;
    settle();
    check_val("rr_idle_busy", busy, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      a_data = 8'hA0 + 8'(i);
      b_data = 8'hB0 + 8'(i);
      a_last = (i == 3);   // last coincides with the beat limit
`ifdef MUX_ARB_FIXED_PRI_EN
      exp_b = 1'b0;
`else
      exp_b = ((i / 4) % 2) == 1;
`endif
      if (i == 1) begin
        y_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          settle();
          check_val("stall_aready", a_ready, 0);
          check_val("stall_ydata",  y_data,  8'hA1);
          check_val("stall_sel",    sel,     0);
          tick();
        end
        y_ready = 1'b1;
      end
      settle();
      check_val("rr_sel",    sel,     32'(exp_b));
      check_val("rr_ydata",  y_data,  exp_b ? 32'(8'hB0 + 8'(i)) : 32'(8'hA0 + 8'(i)));
      check_val("rr_yvalid", y_valid, 1);
      check_val("rr_ylast",  y_last,  (i == 3 && !exp_b) ? 1 : 0);
    end
    do_reset();

    // Both valid with last on every beat: single-beat bursts.
    a_valid = 1'b1; b_valid = 1'b1; a_last = 1'b1; b_last = 1'b1;
    a_data = 8'h01; b_data = 8'h02;
    settle();
    for (int i = 0; i < 4; i++) begin
      tick(); settle();
`ifdef MUX_ARB_FIXED_PRI_EN
      exp_b = 1'b0;
`else
      exp_b = (i % 2) == 1;
`endif
      check_val("last_sel",   sel,    32'(exp_b));
      check_val("last_ydata", y_data, exp_b ? 32'h02 : 32'h01);
    end
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
